chi_inv_iter: RTL and testbench

Iterative inverse of the Keccak-f[1600] χ step. Accepts a 1600-bit state and returns the state A such that χ(A) equals the input. The block exists for the Keccak decryption/debug path and for round-trip self-test of the χ datapath. Inversion is row-serial: a configurable number of 5-bit rows is inverted per cycle through a shared inverse row function, with valid/ready handshakes on both sides.

---
 rtl/chi_inv_iter_pkg.sv | 38 +++
 rtl/chi_inv_iter_if.sv | 34 +++
 rtl/chi_inv_iter_row.sv | 11 +
 rtl/chi_inv_iter.sv | 112 +++++++++++
 tb/tb_chi_inv_iter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/chi_inv_iter_pkg.sv
// Keccak chi-inverse shared package: state geometry, bit indexing,
// forward chi row function and the inverse row table.
package chi_inv_iter_pkg;

  localparam int STATE_W  = 1600;
  localparam int LANE_W   = 64;
  localparam int NUM_ROWS = 320;
  localparam int IDX_W    = $clog2(STATE_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  function automatic int idx(int x, int y, int z);
    return LANE_W * (5 * y + x) + z;
  endfunction

  // Doubled copy turns the mod-5 neighbour indexing into plain slices.
  function automatic logic [4:0] chi_row(logic [4:0] a);
    logic [9:0] aa;
    aa = {a, a};
    return a ^ (~aa[5:1] & aa[6:2]);
  endfunction

  function automatic logic [31:0][4:0] gen_lut();
    logic [31:0][4:0] t;
    t = '0;
    for (int a = 0; a < 32; a++) begin
      t[chi_row(5'(a))] = 5'(a);
    end
    return t;
  endfunction

  localparam logic [31:0][4:0] CHI_INV_LUT = gen_lut();

endpackage

// File: rtl/chi_inv_iter_if.sv
// Handshake bundle for the chi-inverse engine: state in on one side,
// inverted state out on the other.
interface chi_inv_iter_if;
  import chi_inv_iter_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [0:STATE_W-1] S_in;
  logic               out_valid;
  logic               out_ready;
  logic [0:STATE_W-1] S_out;
  logic               busy;

  modport slave (
    input  in_valid,
    input  S_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output S_out,
    output busy
  );

  modport master (
    output in_valid,
    output S_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  S_out,
    input  busy
  );

endinterface

// File: rtl/chi_inv_iter_row.sv
// Single 5-bit row inverse of chi, a pure table lookup.
module chi_inv_row
  import chi_inv_iter_pkg::*;
(
  input  logic [4:0] b_i,
  output logic [4:0] a_o
);

  assign a_o = CHI_INV_LUT[b_i];

endmodule

// File: rtl/chi_inv_iter.sv
// Row-serial chi inverse: a 1600-bit state is captured, inverted
// ROWS_PER_CYCLE rows at a time, then held until taken.
module chi_inv_iter
  import chi_inv_iter_pkg::*;
#(
  parameter int ROWS_PER_CYCLE = 64
) (
  input logic            clk,
  input logic            rst_n,
  chi_inv_iter_if.slave  bus
);

  localparam int RPC  = ROWS_PER_CYCLE;
  localparam int NCYC = NUM_ROWS / RPC;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [0:STATE_W-1] w_q;
  logic [0:STATE_W-1] w_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [4:0] row_in  [RPC];
  logic [4:0] row_out [RPC];

  // Gather the rows selected by cnt into the shared row functions.
  always_comb begin
    int               r;
    logic [IDX_W-1:0] k;
    r = 0;
    k = '0;
    for (int i = 0; i < RPC; i++) begin
      r = int'(cnt_q) * RPC + i;
      for (int x = 0; x < 5; x++) begin
        k = IDX_W'(idx(x, r / LANE_W, r % LANE_W));
        row_in[i][x] = w_q[k];
      end
    end
  end

  for (genvar g = 0; g < RPC; g++) begin : g_row
    chi_inv_row u_row (
      .b_i (row_in[g]),
      .a_o (row_out[g])
    );
  end

  always_comb begin
    int               r;
    logic [IDX_W-1:0] k;
    r   = 0;
    k   = '0;
    w_d = w_q;
    for (int i = 0; i < RPC; i++) begin
      r = int'(cnt_q) * RPC + i;
      for (int x = 0; x < 5; x++) begin
        k = IDX_W'(idx(x, r / LANE_W, r % LANE_W));
        w_d[k] = row_out[i][x];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      w_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            w_q        <= bus.S_in;
            cnt_q      <= '0;
            state_q    <= S_BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_BUSY: begin
          w_q <= w_d;
          if (cnt_q == CW'(NCYC - 1)) begin
            cnt_q       <= '0;
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.S_out     = w_q;

endmodule

// File: tb/tb_chi_inv_iter.sv
// Directed + random bench for chi_inv_iter against a lane-level chi model.
// Three instances cover 64 (main), 16 and 320 rows per cycle.
module tb_chi_inv_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  chi_inv_iter_if b ();
  chi_inv_iter_if b16 ();
  chi_inv_iter_if b320 ();

  chi_inv_iter #(.ROWS_PER_CYCLE(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  chi_inv_iter #(.ROWS_PER_CYCLE(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  chi_inv_iter #(.ROWS_PER_CYCLE(320)) dut320 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b320)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [0:1599] obs,
                           input logic [0:1599] exp);
    int l;
    l = -1;
    for (int i = 0; i < 25; i++) begin
      if (l < 0 && obs[64*i +: 64] !== exp[64*i +: 64]) l = i;
    end
    if (l < 0) l = 0;
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: lane %0d observed %h expected %h",
             tag, l, obs[64*l +: 64], exp[64*l +: 64]);
    end
  endtask

  function automatic logic [0:1599] rand_state();
    logic [0:1599] s;
    for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  // Reference chi on whole lanes: B[x][y] = A[x] ^ (~A[x+1] & A[x+2]).
  function automatic logic [0:1599] chi_ref(input logic [0:1599] a);
    logic [63:0] ln [5][5];
    logic [63:0] o;
    logic [0:1599] s;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        for (int z = 0; z < 64; z++)
          ln[x][y][z] = a[64*(5*y+x)+z];
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) begin
        o = ln[x][y] ^ (~ln[(x+1)%5][y] & ln[(x+2)%5][y]);
        for (int z = 0; z < 64; z++) s[64*(5*y+x)+z] = o[z];
      end
    return s;
  endfunction

  function automatic logic [0:1599] lanes_on(input logic [4:0] xm);
    logic [0:1599] s;
    s = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        for (int z = 0; z < 64; z++)
          s[64*(5*y+x)+z] = xm[x];
    return s;
  endfunction

  task automatic xfer(input logic [0:1599] s, output logic [0:1599] got,
                      output int lat, output int bcnt,
                      input int stall_max);
    int guard;
    int k;
    guard = 0;
    while (!b.in_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("xfer_in_ready", 64'(b.in_ready), 64'd1);
    b.S_in = s;
    b.in_valid = 1'b1;
    step();
    b.in_valid = 1'b0;
    b.S_in = rand_state();
    lat = 1;
    bcnt = 0;
    while (!b.out_valid && lat < 400) begin
      bcnt += int'(b.busy);
      step();
      lat++;
    end
    chk("xfer_out_valid", 64'(b.out_valid), 64'd1);
    got = b.S_out;
    k = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
    for (int i = 0; i < k; i++) begin
      step();
      chk("stall_valid", 64'(b.out_valid), 64'd1);
      chk_state("stall_stable", b.S_out, got);
    end
    b.out_ready = 1'b1;
    step();
    b.out_ready = 1'b0;
    chk("post_hs_valid", 64'(b.out_valid), 64'd0);
    chk("post_hs_ready", 64'(b.in_ready), 64'd1);
  endtask

  initial begin
    logic [0:1599] a;
    logic [0:1599] got;
    logic [0:1599] g16;
    logic [0:1599] g320;
    int lat;
    int bcnt;
    int l64;
    int l16;
    int l320;
    int cyc;
    int acc [$];

    b.in_valid = 0; b.out_ready = 0; b.S_in = '0;
    b16.in_valid = 0; b16.out_ready = 0; b16.S_in = '0;
    b320.in_valid = 0; b320.out_ready = 0; b320.S_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_in_ready", 64'(b.in_ready), 64'd1);
    chk("rst_out_valid", 64'(b.out_valid), 64'd0);
    chk("rst_busy", 64'(b.busy), 64'd0);
    chk_state("rst_S_out", b.S_out, '0);

    xfer('0, got, lat, bcnt, 0);
    chk_state("zero_out", got, '0);
    chk("zero_latency", 64'(lat), 64'd6);
    chk("zero_busy_cycles", 64'(bcnt), 64'd5);

    xfer(lanes_on(5'b01001), got, lat, bcnt, 2);
    chk_state("lanes_0_3", got, lanes_on(5'b00001));

    // All-ones through all three widths at once.
    b.S_in = '1; b16.S_in = '1; b320.S_in = '1;
    b.in_valid = 1; b16.in_valid = 1; b320.in_valid = 1;
    step();
    b.in_valid = 0; b16.in_valid = 0; b320.in_valid = 0;
    l64 = 0; l16 = 0; l320 = 0;
    got = '0; g16 = '0; g320 = '0;
    for (int c = 1; c <= 30; c++) begin
      if (b.out_valid && l64 == 0) begin l64 = c; got = b.S_out; end
      if (b16.out_valid && l16 == 0) begin l16 = c; g16 = b16.S_out; end
      if (b320.out_valid && l320 == 0) begin l320 = c; g320 = b320.S_out; end
      step();
    end
    chk("ones_lat64", 64'(l64), 64'd6);
    chk("ones_lat16", 64'(l16), 64'd21);
    chk("ones_lat320", 64'(l320), 64'd2);
    chk_state("ones_out64", got, '1);
    chk_state("ones_out16", g16, '1);
    chk_state("ones_out320", g320, '1);
    b.out_ready = 1; b16.out_ready = 1; b320.out_ready = 1;
    step();
    b.out_ready = 0; b16.out_ready = 0; b320.out_ready = 0;

    for (int t = 0; t < 100; t++) begin
      a = rand_state();
      xfer(chi_ref(a), got, lat, bcnt, 3);
      chk_state("rand_inverse", got, a);
    end

    // Continuous in_valid with out_ready high: one accept every 7 cycles.
    b.out_ready = 1'b1;
    b.in_valid = 1'b1;
    b.S_in = rand_state();
    for (cyc = 0; cyc < 40; cyc++) begin
      if (b.in_ready) acc.push_back(cyc);
      chk("b2b_ready_excl", 64'(b.in_ready & (b.busy | b.out_valid)), 64'd0);
      step();
    end
    b.in_valid = 1'b0;
    chk("b2b_accepts", 64'(acc.size() >= 5), 64'd1);
    for (int i = 1; i < acc.size(); i++)
      chk("b2b_interval", 64'(acc[i] - acc[i-1]), 64'd7);
    cyc = 0;
    while (!b.in_ready && cyc < 20) begin
      step();
      cyc++;
    end
    b.out_ready = 1'b0;
    chk("b2b_drain", 64'(b.in_ready), 64'd1);

    // Abort mid-BUSY at cnt=2, then a clean transfer.
    b.S_in = rand_state();
    b.in_valid = 1'b1;
    step();
    b.in_valid = 1'b0;
    step();
    step();
    chk("abort_busy_pre", 64'(b.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(b.out_valid), 64'd0);
    chk("abort_in_ready", 64'(b.in_ready), 64'd1);
    chk("abort_busy", 64'(b.busy), 64'd0);
    chk_state("abort_S_out", b.S_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a = rand_state();
    xfer(chi_ref(a), got, lat, bcnt, 1);
    chk_state("after_abort", got, a);
    chk("after_abort_lat", 64'(lat), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
